// File: rtl/execute_operand_stage.sv
// execute_operand_stage: holding register in front of the execute ALU.
// It captures one decoded instruction per handshake and resolves both source
// operands through EX/MEM and MEM/WB forwarding. On a load-use dependency it
// lets the load leave and keeps the dependent instruction out for one cycle.
module execute_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [OP_WIDTH-1:0]       iAluControl,
  input  logic [REG_ADDR_WIDTH-1:0] iRs1Addr,
  input  logic [REG_ADDR_WIDTH-1:0] iRs2Addr,
  input  logic                      iRs1Used,
  input  logic                      iRs2Used,
  input  logic [DATA_WIDTH-1:0]     iRs1Data,
  input  logic [DATA_WIDTH-1:0]     iRs2Data,
  input  logic [DATA_WIDTH-1:0]     iImm,
  input  logic [DATA_WIDTH-1:0]     iPc,
  input  logic                      iOp1Sel,
  input  logic                      iOp2Sel,
  input  logic [REG_ADDR_WIDTH-1:0] iRdAddr,
  input  logic                      iRegWrite,
  input  logic                      iMemRead,
  input  logic                      iMemWrite,
  input  logic                      iFlush,
  input  logic                      iExMemRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] iExMemRdAddr,
  input  logic [DATA_WIDTH-1:0]     iExMemResult,
  input  logic                      iMemWbRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] iMemWbRdAddr,
  input  logic [DATA_WIDTH-1:0]     iMemWbResult,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [OP_WIDTH-1:0]       oAluControl,
  output logic [DATA_WIDTH-1:0]     oAluOp1,
  output logic [DATA_WIDTH-1:0]     oAluOp2,
  output logic [DATA_WIDTH-1:0]     oStoreData,
  output logic [REG_ADDR_WIDTH-1:0] oRdAddr,
  output logic                      oRegWrite,
  output logic                      oMemRead,
  output logic                      oMemWrite
);

  // Fields of the held instruction. The rs used flags only matter for the
  // hazard check against the incoming instruction, so they are not kept.
  typedef struct packed {
    logic [OP_WIDTH-1:0]       alu_control;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic                      op1_sel;
    logic                      op2_sel;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } hold_t;

  hold_t hold_q, hold_d;
  logic  valid_q, valid_d;

  logic load_use;
  logic up_fire;
  logic dn_fire;

  // A held load whose destination is read by the incoming instruction; x0 never counts.
  assign load_use = valid_q && hold_q.mem_read && (hold_q.rd_addr != '0) && iValid &&
                    ((iRs1Used && (iRs1Addr == hold_q.rd_addr)) ||
                     (iRs2Used && (iRs2Addr == hold_q.rd_addr)));

  assign oReady  = (!valid_q || iReady) && !load_use && !iFlush;
  assign up_fire = iValid && oReady;
  assign dn_fire = valid_q && iReady;

  // Next-state selection: flush, then capture, then drain, else hold.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (iFlush) begin
      valid_d = 1'b0;
    end else if (up_fire) begin
      valid_d             = 1'b1;
      hold_d.alu_control  = iAluControl;
      hold_d.rs1_addr     = iRs1Addr;
      hold_d.rs2_addr     = iRs2Addr;
      hold_d.rs1_data     = iRs1Data;
      hold_d.rs2_data     = iRs2Data;
      hold_d.imm          = iImm;
      hold_d.pc           = iPc;
      hold_d.op1_sel      = iOp1Sel;
      hold_d.op2_sel      = iOp2Sel;
      hold_d.rd_addr      = iRdAddr;
      hold_d.reg_write    = iRegWrite;
      hold_d.mem_read     = iMemRead;
      hold_d.mem_write    = iMemWrite;
    end else if (dn_fire) begin
      valid_d = 1'b0;
    end
  end

  // Holding register; reset clears the valid bit and every held field.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  // One forwarding mux per source operand; index 0 is rs1, index 1 is rs2.
  // It is re-evaluated every cycle so a stalled instruction picks up results
  // as the later stages advance.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     fwd;

    assign rs_addr = (gi == 0) ? hold_q.rs1_addr : hold_q.rs2_addr;
    assign rs_data = (gi == 0) ? hold_q.rs1_data : hold_q.rs2_data;

    // EX/MEM is the younger result and wins over MEM/WB.
    always_comb begin
      fwd = rs_data;
      if (rs_addr != '0) begin
        if (iExMemRegWrite && (iExMemRdAddr == rs_addr)) begin
          fwd = iExMemResult;
        end else if (iMemWbRegWrite && (iMemWbRdAddr == rs_addr)) begin
          fwd = iMemWbResult;
        end
      end
    end
  end

  assign oValid      = valid_q;
  assign oAluControl = hold_q.alu_control;
  assign oAluOp1     = hold_q.op1_sel ? hold_q.pc  : g_fwd[0].fwd;
  assign oAluOp2     = hold_q.op2_sel ? hold_q.imm : g_fwd[1].fwd;
  assign oStoreData  = g_fwd[1].fwd;
  assign oRdAddr     = hold_q.rd_addr;
  assign oRegWrite   = hold_q.reg_write && valid_q;
  assign oMemRead    = hold_q.mem_read  && valid_q;
  assign oMemWrite   = hold_q.mem_write && valid_q;

endmodule
